// File: rtl/uart_rx.sv
// Oversampling UART receiver (8 data bits, optional parity, 1 stop bit).
// Consumes the baud generator's oversample tick, synchronises the serial
// line, validates the start bit at mid-bit, samples data LSB-first, checks
// parity/stop and loads a single holding register read via rx_rd.
//
// Ports:
//   pclk, prst      - system clock, asynchronous active-high reset
//   uart_rxd        - asynchronous serial input, idle high
//   brg_rx_shift    - one-pclk oversample tick
//   apb_en          - receiver enable (0 aborts and holds the FSM in IDLE)
//   apb_bsel        - oversample ratio select: 0 = 16x, 1 = 8x
//   apb_pen/apb_eps - parity enable / even (1) or odd (0) parity
//   rx_rd           - one-cycle read strobe, clears rx_full and rx_oerr
//   rx_data         - last received byte
//   rx_full         - unread byte present
//   rx_ferr/rx_perr - framing / parity error of the last loaded frame
//   rx_oerr         - sticky overrun
//   rx_busy         - FSM not in IDLE
module uart_rx (
  input  logic       pclk,
  input  logic       prst,
  input  logic       uart_rxd,
  input  logic       brg_rx_shift,
  input  logic       apb_en,
  input  logic       apb_bsel,
  input  logic       apb_pen,
  input  logic       apb_eps,
  input  logic       rx_rd,
  output logic [7:0] rx_data,
  output logic       rx_full,
  output logic       rx_ferr,
  output logic       rx_perr,
  output logic       rx_oerr,
  output logic       rx_busy
);

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;
  localparam int unsigned BW = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state;
  logic            rxd_m;
  logic            rxd_s;
  logic [SW-1:0]   samcnt;
  logic [BW-1:0]   bitcnt;
  logic [DW-1:0]   shreg;
  logic            par_bit;

  logic [SW-1:0]   half_m1;
  logic [SW-1:0]   full_m1;
  logic            par_x;

  // Tick counts for the mid-start sample and the full bit period.
  assign half_m1 = apb_bsel ? SW'(3)  : SW'(7);
  assign full_m1 = apb_bsel ? SW'(7)  : SW'(15);

  // Zero for a frame whose data+parity has an even number of ones.
  assign par_x = ^{shreg, par_bit};

  // Synchroniser, receive FSM and holding register.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rxd_m   <= 1'b1;
      rxd_s   <= 1'b1;
      state   <= S_IDLE;
      samcnt  <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      rx_data <= '0;
      rx_full <= 1'b0;
      rx_ferr <= 1'b0;
      rx_perr <= 1'b0;
      rx_oerr <= 1'b0;
      rx_busy <= 1'b0;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;

      // Read clears; a load later in this block overrides it.
      if (rx_rd) begin
        rx_full <= 1'b0;
        rx_oerr <= 1'b0;
      end

      if (!apb_en) begin
        state   <= S_IDLE;
        samcnt  <= '0;
        bitcnt  <= '0;
        rx_busy <= 1'b0;
      end else if (brg_rx_shift) begin
        case (state)
          S_IDLE: begin
            if (!rxd_s) begin
              state   <= S_START;
              samcnt  <= '0;
              rx_busy <= 1'b1;
            end
          end

          S_START: begin
            if (samcnt == half_m1) begin
              if (rxd_s) begin
                state   <= S_IDLE;
                rx_busy <= 1'b0;
              end else begin
                state  <= S_DATA;
                samcnt <= '0;
                bitcnt <= '0;
              end
            end else begin
              samcnt <= samcnt + SW'(1);
            end
          end

          S_DATA: begin
            if (samcnt == full_m1) begin
              shreg  <= {rxd_s, shreg[DW-1:1]};
              samcnt <= '0;
              bitcnt <= bitcnt + BW'(1);
              if (bitcnt == BW'(DW - 1)) begin
                state <= apb_pen ? S_PARITY : S_STOP;
              end
            end else begin
              samcnt <= samcnt + SW'(1);
            end
          end

          S_PARITY: begin
            if (samcnt == full_m1) begin
              par_bit <= rxd_s;
              samcnt  <= '0;
              state   <= S_STOP;
            end else begin
              samcnt <= samcnt + SW'(1);
            end
          end

          S_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is caught.
            if (samcnt == full_m1) begin
              rx_data <= shreg;
              rx_full <= 1'b1;
              rx_ferr <= ~rxd_s;
              rx_perr <= apb_pen & (apb_eps ? par_x : ~par_x);
              rx_oerr <= rx_oerr | (rx_full & ~rx_rd);
              samcnt  <= '0;
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              samcnt <= samcnt + SW'(1);
            end
          end

          default: begin
            state   <= S_IDLE;
            samcnt  <= '0;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of single frames plus hand-written sequences for
// glitch, overrun, read-on-load, 8x back-to-back and abort cases. Expected
// load results are queued when a frame is sent and compared when rx_busy
// falls at the load edge.
module tb_uart_rx;

  logic       pclk = 1'b0;
  logic       prst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       brg_rx_shift = 1'b0;
  logic       apb_en = 1'b0;
  logic       apb_bsel = 1'b0;
  logic       apb_pen = 1'b0;
  logic       apb_eps = 1'b0;
  logic       rx_rd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_full;
  logic       rx_ferr;
  logic       rx_perr;
  logic       rx_oerr;
  logic       rx_busy;

  uart_rx dut (
    .pclk         (pclk),
    .prst         (prst),
    .uart_rxd     (uart_rxd),
    .brg_rx_shift (brg_rx_shift),
    .apb_en       (apb_en),
    .apb_bsel     (apb_bsel),
    .apb_pen      (apb_pen),
    .apb_eps      (apb_eps),
    .rx_rd        (rx_rd),
    .rx_data      (rx_data),
    .rx_full      (rx_full),
    .rx_ferr      (rx_ferr),
    .rx_perr      (rx_perr),
    .rx_oerr      (rx_oerr),
    .rx_busy      (rx_busy)
  );

  always #5 pclk = ~pclk;

  // Oversample tick: one pclk high every 4 pclk.
  initial begin
    forever begin
      repeat (3) @(posedge pclk);
      #1 brg_rx_shift = 1'b1;
      @(posedge pclk);
      #1 brg_rx_shift = 1'b0;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       full;
    logic       ferr;
    logic       perr;
    logic       oerr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       eps;
    logic       par;
    logic       stop;
    logic       ferr;
    logic       perr;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_err = 0;
  int   n_checks = 0;
  logic busy_q = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the queued expectation on each load (rx_busy falling).
  always @(negedge pclk) begin
    if (prst) begin
      busy_q = 1'b0;
    end else begin
      if (busy_q && !rx_busy && sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("load_data", rx_data, mon_e.data);
        chk("load_full", 8'(rx_full), 8'(mon_e.full));
        chk("load_ferr", 8'(rx_ferr), 8'(mon_e.ferr));
        chk("load_perr", 8'(rx_perr), 8'(mon_e.perr));
        chk("load_oerr", 8'(rx_oerr), 8'(mon_e.oerr));
      end
      busy_q = rx_busy;
    end
  end

  function automatic int bp();
    return (apb_bsel ? 8 : 16) * 4;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    uart_rxd = 1'b0;
    repeat (bp()) @(posedge pclk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (bp()) @(posedge pclk);
    end
    if (apb_pen) begin
      uart_rxd = par;
      repeat (bp()) @(posedge pclk);
    end
    uart_rxd = stop;
    repeat (bp()) @(posedge pclk);
    uart_rxd = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input logic full, input logic ferr,
                      input logic perr, input logic oerr);
    exp_t e;
    e.data = d; e.full = full; e.ferr = ferr; e.perr = perr; e.oerr = oerr;
    sb.push_back(e);
  endtask

  task automatic gap();
    repeat (2 * bp()) @(posedge pclk);
  endtask

  task automatic pulse_rd();
    @(posedge pclk);
    #1 rx_rd = 1'b1;
    @(posedge pclk);
    #1 rx_rd = 1'b0;
    @(negedge pclk);
  endtask

  task automatic chk_drained(input string name);
    @(negedge pclk);
    chk(name, 8'(sb.size()), 8'd0);
    sb.delete();
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{data: 8'hA5, pen: 1'b0, eps: 1'b0, par: 1'b0, stop: 1'b1, ferr: 1'b0, perr: 1'b0};
    vecs[1] = '{data: 8'h37, pen: 1'b1, eps: 1'b1, par: 1'b1, stop: 1'b1, ferr: 1'b0, perr: 1'b0};
    vecs[2] = '{data: 8'h37, pen: 1'b1, eps: 1'b1, par: 1'b0, stop: 1'b1, ferr: 1'b0, perr: 1'b1};
    vecs[3] = '{data: 8'h37, pen: 1'b1, eps: 1'b0, par: 1'b0, stop: 1'b1, ferr: 1'b0, perr: 1'b0};
    vecs[4] = '{data: 8'h81, pen: 1'b0, eps: 1'b0, par: 1'b0, stop: 1'b0, ferr: 1'b1, perr: 1'b0};
    vecs[5] = '{data: 8'h00, pen: 1'b0, eps: 1'b0, par: 1'b0, stop: 1'b1, ferr: 1'b0, perr: 1'b0};

    // Reset values
    repeat (5) @(posedge pclk);
    @(negedge pclk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_full", 8'(rx_full), 8'd0);
    chk("rst_ferr", 8'(rx_ferr), 8'd0);
    chk("rst_perr", 8'(rx_perr), 8'd0);
    chk("rst_oerr", 8'(rx_oerr), 8'd0);
    chk("rst_busy", 8'(rx_busy), 8'd0);
    prst = 1'b0;
    apb_en = 1'b1;
    gap();

    // Table of single frames, 16x, each read back afterwards
    for (int v = 0; v < 6; v++) begin
      apb_pen = vecs[v].pen;
      apb_eps = vecs[v].eps;
      push(vecs[v].data, 1'b1, vecs[v].ferr, vecs[v].perr, 1'b0);
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
      chk_drained("vec_loaded");
      gap();
      pulse_rd();
      chk("vec_rd_full", 8'(rx_full), 8'd0);
    end
    apb_pen = 1'b0;
    apb_eps = 1'b0;

    // Low glitch of 5 ticks is rejected as a false start
    uart_rxd = 1'b0;
    repeat (20) @(posedge pclk);
    uart_rxd = 1'b1;
    repeat (120) @(posedge pclk);
    @(negedge pclk);
    chk("glitch_busy", 8'(rx_busy), 8'd0);
    chk("glitch_full", 8'(rx_full), 8'd0);
    push(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1);
    chk_drained("glitch_next_loaded");
    gap();
    pulse_rd();

    // Overrun: two frames without a read
    push(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b1);
    gap();
    push(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    chk_drained("ovr_loaded");
    gap();
    pulse_rd();
    chk("ovr_rd_full", 8'(rx_full), 8'd0);
    chk("ovr_rd_oerr", 8'(rx_oerr), 8'd0);
    chk("ovr_rd_data", rx_data, 8'h22);

    // Read strobe on the load edge of a second unread frame: load wins
    push(8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b1);
    gap();
    push(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h55, 1'b0, 1'b1);
      begin
        for (int i = 0; i < 2000 && !rx_busy; i++) @(negedge pclk);
        if (rx_busy) begin
          // Load edge is 152 ticks (8 + 9*16) after the detection edge
          repeat (152 * 4 - 1) @(posedge pclk);
          #1 rx_rd = 1'b1;
          @(posedge pclk);
          #1 rx_rd = 1'b0;
        end else begin
          chk("rdload_busy_timeout", 8'(rx_busy), 8'd1);
        end
      end
    join
    chk_drained("rdload_loaded");
    chk("rdload_full", 8'(rx_full), 8'd1);
    chk("rdload_oerr", 8'(rx_oerr), 8'd0);
    gap();
    pulse_rd();

    // 8x back-to-back frames; second overruns the unread first
    apb_bsel = 1'b1;
    gap();
    push(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    push(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1);
    chk_drained("b2b_loaded");
    gap();
    pulse_rd();
    apb_bsel = 1'b0;
    gap();

    // Disable mid-frame: aborted, nothing loaded, holding register kept
    fork
      send_frame(8'h77, 1'b0, 1'b1);
      begin
        repeat (3 * 64) @(posedge pclk);
        @(negedge pclk);
        chk("en_busy_before", 8'(rx_busy), 8'd1);
        @(posedge pclk);
        #1 apb_en = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        chk("en_busy_after", 8'(rx_busy), 8'd0);
      end
    join
    gap();
    @(negedge pclk);
    chk("en_full", 8'(rx_full), 8'd0);
    chk("en_data", rx_data, 8'hC3);
    chk("en_busy_idle", 8'(rx_busy), 8'd0);
    apb_en = 1'b1;
    gap();

    // Reset mid-frame with an unread byte present
    push(8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h99, 1'b0, 1'b1);
    chk_drained("prst_pre_loaded");
    gap();
    fork
      send_frame(8'h66, 1'b0, 1'b1);
      begin
        repeat (3 * 64) @(posedge pclk);
        #2 prst = 1'b1;
        #1;
        chk("prst_data", rx_data, 8'h00);
        chk("prst_full", 8'(rx_full), 8'd0);
        chk("prst_ferr", 8'(rx_ferr), 8'd0);
        chk("prst_perr", 8'(rx_perr), 8'd0);
        chk("prst_oerr", 8'(rx_oerr), 8'd0);
        chk("prst_busy", 8'(rx_busy), 8'd0);
      end
    join
    gap();
    prst = 1'b0;
    gap();
    @(negedge pclk);
    chk("prst_after_full", 8'(rx_full), 8'd0);
    chk("prst_after_data", rx_data, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver that consumes the `brg_rx_shift` oversample tick from the UART baud-rate generator. It synchronises the serial input, detects and validates the start bit, samples 8 data bits LSB-first at mid-bit, and optionally checks a parity bit before checking the stop bit. Each completed frame goes into a single holding register. The APB register block reads that register and its status flags through a one-cycle read strobe.

## Interface
- No parameters. Data width is fixed at 8 bits and there is one stop bit.
- `pclk` in 1: system clock; all logic is on its rising edge.
- `prst` in 1: asynchronous, active-high reset.
- `uart_rxd` in 1: serial line; idle high; asynchronous to `pclk`.
- `brg_rx_shift` in 1: one-`pclk` oversample tick from the baud generator.
- `apb_en` in 1: receiver enable; 0 forces IDLE.
- `apb_bsel` in 1: oversample ratio N. 0 gives N=16; 1 gives N=8. Must match the generator's `apb_bsel`.
- `apb_pen` in 1: parity enable.
- `apb_eps` in 1: parity select. 1 = even, 0 = odd.
- `rx_rd` in 1: one-cycle read strobe; clears `rx_full` and `rx_oerr`.
- `rx_data` out 8: last received byte.
- `rx_full` out 1: the holding register holds an unread byte.
- `rx_ferr` out 1: framing error of the last loaded frame (stop bit sampled 0).
- `rx_perr` out 1: parity error of the last loaded frame; forced 0 when `apb_pen`=0.
- `rx_oerr` out 1: overrun, sticky. A frame was loaded while `rx_full`=1.
- `rx_busy` out 1: the FSM is not in IDLE.

## Operation
- Input synchroniser:
  - `uart_rxd` passes through two flops; both reset to 1.
  - Its output `rxd_s` is the only line sample the FSM uses.
- Counters and shift register:
  - `samcnt` is 4 bits and counts ticks within a bit.
  - `bitcnt` is 3 bits.
  - `shreg` is 8 bits; bits shift in at bit 7 and move right (LSB-first line order).
- All FSM state changes and counter updates happen only on cycles where `brg_rx_shift`=1, except the `apb_en`=0 and reset cases.
- FSM states and transitions:
  - IDLE: on a tick with `rxd_s`=0, go to START with `samcnt`=0.
  - START: on each tick, increment `samcnt`. When `samcnt` reaches N/2−1 (7 or 3), sample `rxd_s`:
    - 1 means a false start; go to IDLE.
    - 0: clear `samcnt` and `bitcnt`, go to DATA.
  - DATA: on each tick, increment `samcnt`. When `samcnt` reaches N−1, sample `rxd_s` into `shreg`, clear `samcnt`, increment `bitcnt`. After the 8th bit (`bitcnt` wraps from 7), go to PARITY if `apb_pen`=1, otherwise go to STOP.
  - PARITY: at `samcnt`=N−1, capture the parity bit, clear `samcnt`, go to STOP.
  - STOP: at `samcnt`=N−1, sample the stop bit, load the holding register, go to IDLE. The FSM returns to IDLE at mid-stop-bit so a back-to-back start bit is caught.
- Parity check:
  - Let `x` = XOR of the 8 data bits and the parity bit.
  - Even parity (`apb_eps`=1): `rx_perr` = `x`.
  - Odd parity (`apb_eps`=0): `rx_perr` = ~`x`.
- Load action:
  - `rx_data` ← `shreg`.
  - `rx_full` ← 1.
  - `rx_ferr` ← ~stop.
  - `rx_perr` as above.
  - `rx_oerr` ← `rx_oerr` | (`rx_full` & ~`rx_rd`).
  - A frame with a framing error is still loaded.
- Overrun: a new frame overwrites `rx_data`. The unread byte is lost.
- `rx_rd` without a load: `rx_full` ← 0 and `rx_oerr` ← 0. `rx_data`, `rx_ferr` and `rx_perr` hold.
- `rx_rd` in the same cycle as a load: the load wins. `rx_full` stays 1 and no overrun is flagged.
- `apb_en`=0:
  - The FSM is forced to IDLE and the counters are cleared on the next `pclk`, tick or no tick.
  - A frame in progress is aborted with no load.
  - The holding register and flags are retained.
- `apb_bsel`, `apb_pen` and `apb_eps` must be stable while `rx_busy`=1. Behaviour when they change mid-frame is undefined but must not lock up the FSM.

## Timing
- Reset values:
  - `rx_data`=0x00.
  - `rx_full`, `rx_ferr`, `rx_perr`, `rx_oerr`, `rx_busy` = 0.
  - FSM in IDLE, synchroniser flops = 1.
- Input latency: 2 `pclk` from `uart_rxd` to `rxd_s`, plus detection on the next tick.
- Sample points:
  - Start bit at N/2 ticks after detection.
  - Each later bit exactly N ticks after the previous sample.
- `rx_full` and the error flags update on the `pclk` edge of the tick that samples the stop bit. They are visible in the following cycle.
- `rx_busy` rises on the edge where IDLE→START is taken and falls on the load edge.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). No partial byte is loaded.

## Test plan
- Mode 16x, no parity, tick every 4 `pclk`. Send 0xA5 with a good stop bit → `rx_data`=0xA5, `rx_full`=1, all error flags 0. Pulse `rx_rd` → `rx_full`=0.
- Mode 16x. Drive a low glitch on `uart_rxd` lasting 5 ticks → FSM returns to IDLE, `rx_full` stays 0. Then a valid 0x3C frame → `rx_data`=0x3C.
- Parity enabled, even. Send 0x37 (five ones) with parity bit 1 → `rx_perr`=0. Repeat with parity bit 0 → `rx_perr`=1. With odd parity and parity bit 0 → `rx_perr`=0.
- Send 0x81 with stop bit 0 → `rx_data`=0x81, `rx_ferr`=1. The next good frame 0x00 → `rx_ferr`=0.
- Overrun and simultaneous events:
  - Send 0x11 then 0x22 with no read → `rx_data`=0x22, `rx_oerr`=1. `rx_rd` clears `rx_oerr` and `rx_full`.
  - Assert `rx_rd` on the load cycle → `rx_full`=1, `rx_oerr`=0.
- Mode 8x (`apb_bsel`=1): back-to-back frames 0x5A and 0xC3 with a single stop bit → both received correctly.
- Abort cases:
  - Deassert `apb_en` mid-frame → no load, `rx_busy`=0.
  - Assert `prst` mid-frame → all outputs reset.
